// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divider helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;
  localparam logic [3:0] T_LAST   = 4'(OVERSAMPLE - 1);

  // Clamped to 1 so a too-fast baud request still yields a working divider.
  function automatic int calc_div(input int clk_freq, input int baud);
    int div;
    div = clk_freq / (baud * OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator; restart realigns the tick phase to a
// detected start edge.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: start-bit validation, 3-sample majority voting,
// optional parity, stop check and a small byte FIFO with valid/ready output.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  logic rx_meta, rxs, rxs_q;
  logic tick, start_edge, vote, push, pop, full, empty;
  rx_state_t state;
  logic [3:0] t;
  logic [2:0] n;
  logic s_a, s_b, par_bad;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  // rxs_q is only the edge-detect history of the synchronised line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign start_edge = (state == IDLE) && rxs_q && !rxs;
  assign vote = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(start_edge),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      n          <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      par_bad    <= 1'b0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= START;
            t       <= '0;
            n       <= '0;
            par_bad <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: begin
          if (tick) begin
            t <= t + 4'd1;
            if (t == SAMPLE_A) s_a <= rxs;
            if (t == SAMPLE_B) s_b <= rxs;
            case (state)
              START: begin
                if (t == SAMPLE_A && rxs) state <= IDLE;
                else if (t == T_LAST)     state <= DATA;
              end
              DATA: begin
                if (t == SAMPLE_C) shreg <= {vote, shreg[DATA_BITS-1:1]};
                if (t == T_LAST) begin
                  if (n == N_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
                  else             n <= n + 3'd1;
                end
              end
              PARITY: begin
                if (t == SAMPLE_C) par_bad <= (vote != ((^shreg) ^ ODD));
                if (t == T_LAST)   state <= STOP;
              end
              STOP: begin
                // A low stop bit wins over parity so only one flag fires per frame.
                if (t == SAMPLE_C) begin
                  if (!vote) begin
                    frame_err <= 1'b1;
                    state     <= WAIT_HIGH;
                  end else begin
                    parity_err <= par_bad;
                    state      <= IDLE;
                  end
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign push = (state == STOP) && tick && (t == SAMPLE_C) && vote && !par_bad;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && full && !pop;
      if (push && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
